// File: rtl/analog_control_emu.sv
// -----------------------------------------------------------------------------
// analog_control_emu
//
// Turns digital +/- buttons into analog control values (steering, gas,
// paddles), one value per channel. Each value is updated once per video frame.
// A channel can instead follow an external analog value (joystick).
// Per channel, in priority order:
//   - analog follow (clamped),
//   - ramp up or down with step acceleration and clamping,
//   - self-center or hold when released.
//
// Ports
//   clock_40     in   core clock
//   reset_n      in   asynchronous active-low reset
//   vsync        in   video vsync, asynchronous, active high (frame tick source)
//   btn_plus     in   [CHANNELS]        per-channel increase button
//   btn_minus    in   [CHANNELS]        per-channel decrease button
//   self_center  in   [CHANNELS]        1 = return to CENTER on release
//   ana_en       in   [CHANNELS]        1 = channel follows ana_in
//   ana_in       in   [CHANNELS*WIDTH]  analog values, channel k at [k*WIDTH +: WIDTH]
//   value_out    out  [CHANNELS*WIDTH]  emulated control values, same packing
//   moving       out  [CHANNELS]        1 = value changed on the last tick
// -----------------------------------------------------------------------------
module analog_control_emu #(
  parameter int unsigned       CHANNELS     = 2,
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  CENTER       = 8'h80,
  parameter logic [WIDTH-1:0]  MIN_VAL      = 8'h10,
  parameter logic [WIDTH-1:0]  MAX_VAL      = 8'hF0,
  parameter int unsigned       STEP_MIN     = 1,
  parameter int unsigned       STEP_MAX     = 8,
  parameter int unsigned       ACCEL_FRAMES = 4
) (
  input  logic                      clock_40,
  input  logic                      reset_n,
  input  logic                      vsync,
  input  logic [CHANNELS-1:0]       btn_plus,
  input  logic [CHANNELS-1:0]       btn_minus,
  input  logic [CHANNELS-1:0]       self_center,
  input  logic [CHANNELS-1:0]       ana_en,
  input  logic [CHANNELS*WIDTH-1:0] ana_in,
  output logic [CHANNELS*WIDTH-1:0] value_out,
  output logic [CHANNELS-1:0]       moving
);

  if (!(MIN_VAL <= CENTER && CENTER <= MAX_VAL &&
        STEP_MIN >= 1 && STEP_MIN <= STEP_MAX)) begin : g_param_check
    $error("analog_control_emu: need MIN_VAL<=CENTER<=MAX_VAL and 1<=STEP_MIN<=STEP_MAX");
  end

  localparam int unsigned      CNT_W    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [WIDTH-1:0] STEP_LO  = WIDTH'(STEP_MIN);
  localparam logic [WIDTH-1:0] STEP_HI  = WIDTH'(STEP_MAX);

  typedef enum logic [1:0] {S_IDLE, S_INC, S_DEC, S_CENTERING} state_e;

  // ---------------------------------------------------------------------------
  // Frame tick: 2-flop synchronizer, rising-edge detect, registered pulse.
  // The tick is high in the 3rd clock after the vsync rise.
  // ---------------------------------------------------------------------------
  logic vsync_meta_q, vsync_sync_q, vsync_prev_q, tick_q;

  // NOTE: every register uses <= and the async reset arm. Blocking writes in
  // clocked blocks create ordering races between processes.
  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      vsync_meta_q <= 1'b0;
      vsync_sync_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      vsync_meta_q <= vsync;
      vsync_sync_q <= vsync_meta_q;
      vsync_prev_q <= vsync_sync_q;
      tick_q       <= vsync_sync_q & ~vsync_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating arithmetic. Sums are formed one bit wider so a value never wraps.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] s);
    logic [WIDTH:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    return (sum > {1'b0, MAX_VAL}) ? MAX_VAL : sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] s);
    logic [WIDTH:0] floor_v;
    floor_v = {1'b0, MIN_VAL} + {1'b0, s};
    return ({1'b0, v} < floor_v) ? MIN_VAL : v - s;
  endfunction

  function automatic logic [WIDTH-1:0] toward_center(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > CENTER) r = ((v - CENTER) <= STEP_LO) ? CENTER : v - STEP_LO;
    else            r = ((CENTER - v) <= STEP_LO) ? CENTER : v + STEP_LO;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
    if (a < MIN_VAL)      r = MIN_VAL;
    else if (a > MAX_VAL) r = MAX_VAL;
    else                  r = a;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Independent channels
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_e           state_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] step_q;
    logic [CNT_W-1:0] count_q;
    logic             moving_q;

    logic             plus, minus;
    logic [WIDTH-1:0] ana_val, inc_val, dec_val, ctr_val, run_step;
    logic [CNT_W-1:0] run_cnt;

    always_comb begin
      plus    = btn_plus[k]  & ~btn_minus[k];
      minus   = btn_minus[k] & ~btn_plus[k];
      ana_val = clamp(ana_in[k*WIDTH +: WIDTH]);
      // The first tick of a run (including a reversal) moves by STEP_MIN.
      inc_val = sat_add(value_q, (state_q == S_INC) ? step_q : STEP_LO);
      dec_val = sat_sub(value_q, (state_q == S_DEC) ? step_q : STEP_LO);
      ctr_val = toward_center(value_q);
      // count_q wraps modulo ACCEL_FRAMES, so each step size lasts exactly
      // ACCEL_FRAMES ticks. The increase takes effect on the following tick.
      run_cnt  = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
      run_step = (run_cnt == CNT_LAST && step_q < STEP_HI) ? step_q + 1'b1 : step_q;
    end

    always_ff @(posedge clock_40 or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= S_IDLE;
        value_q  <= CENTER;
        step_q   <= STEP_LO;
        count_q  <= '0;
        moving_q <= 1'b0;
      end else if (tick_q) begin
        if (ana_en[k]) begin
          state_q  <= S_IDLE;
          value_q  <= ana_val;
          step_q   <= STEP_LO;
          count_q  <= '0;
          moving_q <= (ana_val != value_q);
        end else if (plus) begin
          state_q  <= S_INC;
          value_q  <= inc_val;
          moving_q <= (inc_val != value_q);
          step_q   <= (state_q == S_INC) ? run_step : STEP_LO;
          count_q  <= (state_q == S_INC) ? run_cnt  : '0;
        end else if (minus) begin
          state_q  <= S_DEC;
          value_q  <= dec_val;
          moving_q <= (dec_val != value_q);
          step_q   <= (state_q == S_DEC) ? run_step : STEP_LO;
          count_q  <= (state_q == S_DEC) ? run_cnt  : '0;
        end else begin
          // Released, or both buttons held.
          step_q  <= STEP_LO;
          count_q <= '0;
          if (self_center[k] && value_q != CENTER) begin
            state_q  <= S_CENTERING;
            value_q  <= ctr_val;
            moving_q <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            moving_q <= 1'b0;
          end
        end
      end
    end

    assign value_out[k*WIDTH +: WIDTH] = value_q;
    assign moving[k]                   = moving_q;
  end

endmodule

// File: tb/tb_analog_control_emu.sv
// -----------------------------------------------------------------------------
// tb_analog_control_emu
//
// Drives frame ticks through vsync and compares both channels against a
// behavioural model. The model tracks direction, step size and the number of
// ticks spent at the current step. The bench runs directed scenarios with
// literal expected values, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_analog_control_emu;

  localparam int CENTER = 'h80;
  localparam int MINV   = 'h10;
  localparam int MAXV   = 'hF0;
  localparam int SMIN   = 1;
  localparam int SMAX   = 8;
  localparam int ACCEL  = 4;

  logic        clock_40 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        vsync    = 1'b0;
  logic [1:0]  btn_plus = '0, btn_minus = '0, self_center = '0, ana_en = '0;
  logic [15:0] ana_in   = '0;
  logic [15:0] value_out;
  logic [1:0]  moving;

  always #5 clock_40 = ~clock_40;

  analog_control_emu dut (
    .clock_40    (clock_40),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .btn_plus    (btn_plus),
    .btn_minus   (btn_minus),
    .self_center (self_center),
    .ana_en      (ana_en),
    .ana_in      (ana_in),
    .value_out   (value_out),
    .moving      (moving)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_val[2], m_step[2], m_run[2], m_dir[2], m_mov[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = CENTER; m_step[k] = SMIN; m_run[k] = 0; m_dir[k] = 0; m_mov[k] = 0;
    end
  endtask

  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      int v, nv, a, d;
      bit p, m;
      v = m_val[k];
      p = btn_plus[k] && !btn_minus[k];
      m = btn_minus[k] && !btn_plus[k];
      if (ana_en[k]) begin
        a  = int'(ana_in[k*8 +: 8]);
        nv = (a < MINV) ? MINV : ((a > MAXV) ? MAXV : a);
        m_dir[k] = 0; m_step[k] = SMIN; m_run[k] = 0;
      end else if (p || m) begin
        d = p ? 1 : -1;
        if (m_dir[k] != d) begin
          m_dir[k] = d; m_step[k] = SMIN; m_run[k] = 0;
        end
        nv = v + d * m_step[k];
        if (nv > MAXV) nv = MAXV;
        if (nv < MINV) nv = MINV;
        m_run[k]++;
        if (m_run[k] == ACCEL) begin
          m_step[k] = (m_step[k] + 1 > SMAX) ? SMAX : m_step[k] + 1;
          m_run[k]  = 0;
        end
      end else begin
        m_dir[k] = 0; m_step[k] = SMIN; m_run[k] = 0;
        if (self_center[k] && v != CENTER) begin
          if ((v > CENTER ? v - CENTER : CENTER - v) <= SMIN) nv = CENTER;
          else nv = (v > CENTER) ? v - SMIN : v + SMIN;
        end else begin
          nv = v;
        end
      end
      m_mov[k] = (nv != v) ? 1 : 0;
      m_val[k] = nv;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_val%0d", tag, k), 32'(value_out[k*8 +: 8]), m_val[k]);
      check($sformatf("%s_mov%0d", tag, k), 32'(moving[k]), m_mov[k]);
    end
  endtask

  task automatic do_reset();
    @(negedge clock_40);
    reset_n = 1'b0;
    repeat (2) @(negedge clock_40);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One frame: apply inputs, pulse vsync, wait past the update, compare.
  task automatic tick(input logic [1:0] p, input logic [1:0] m, input logic [1:0] sc,
                      input logic [1:0] ae, input logic [15:0] ai, input string tag);
    @(negedge clock_40);
    btn_plus = p; btn_minus = m; self_center = sc; ana_en = ae; ana_in = ai;
    vsync = 1'b1;
    repeat (2) @(negedge clock_40);
    vsync = 1'b0;
    repeat (4) @(negedge clock_40);
    model_tick();
    check_all(tag);
  endtask

  int seq_ramp[12] = '{'h81, 'h82, 'h83, 'h84, 'h86, 'h88, 'h8A, 'h8C,
                       'h8F, 'h92, 'h95, 'h98};
  int seq_ctr[5]   = '{'h83, 'h82, 'h81, 'h80, 'h80};

  initial begin
    // Reset state
    model_reset();
    repeat (3) @(negedge clock_40);
    check_all("reset");
    reset_n = 1'b1;

    // Idle frames keep the center value
    for (int i = 0; i < 3; i++) tick(2'b00, 2'b00, 2'b11, 2'b00, 16'h0, "idle");
    check("idle_ch0", 32'(value_out[7:0]), 'h80);
    check("idle_ch1", 32'(value_out[15:8]), 'h80);

    // Acceleration ramp on ch0
    for (int i = 0; i < 12; i++) begin
      tick(2'b01, 2'b00, 2'b00, 2'b00, 16'h0, "ramp");
      check($sformatf("ramp_lit%0d", i), 32'(value_out[7:0]), seq_ramp[i]);
    end
    check("ramp_ch1", 32'(value_out[15:8]), 'h80);

    // Async reset mid-ramp (no clock edge in between)
    @(negedge clock_40);
    reset_n = 1'b0;
    #1;
    check("rst_async_val", 32'(value_out[7:0]), 'h80);
    check("rst_async_mov", 32'(moving), 0);
    @(negedge clock_40);
    reset_n = 1'b1;
    model_reset();
    tick(2'b01, 2'b00, 2'b00, 2'b00, 16'h0, "post_rst");
    check("post_rst_lit", 32'(value_out[7:0]), 'h81);

    // Saturation at MAX_VAL, then reversal
    for (int i = 0; i < 60; i++) tick(2'b01, 2'b00, 2'b00, 2'b00, 16'h0, "sat");
    check("sat_lit", 32'(value_out[7:0]), 'hF0);
    check("sat_mov", 32'(moving[0]), 0);
    tick(2'b00, 2'b01, 2'b00, 2'b00, 16'h0, "rev");
    check("rev_lit", 32'(value_out[7:0]), 'hEF);

    // Self-centering from 84
    do_reset();
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 2'b01, 2'b00, 16'h0, "to84");
    for (int i = 0; i < 5; i++) begin
      tick(2'b00, 2'b00, 2'b01, 2'b00, 16'h0, "ctr");
      check($sformatf("ctr_lit%0d", i), 32'(value_out[7:0]), seq_ctr[i]);
    end
    check("ctr_mov_end", 32'(moving[0]), 0);

    // Hold mode and both-pressed
    do_reset();
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 2'b00, 2'b00, 16'h0, "to84b");
    tick(2'b00, 2'b00, 2'b00, 2'b00, 16'h0, "hold");
    check("hold_lit", 32'(value_out[7:0]), 'h84);
    tick(2'b01, 2'b01, 2'b00, 2'b00, 16'h0, "both");
    check("both_lit", 32'(value_out[7:0]), 'h84);
    tick(2'b01, 2'b01, 2'b01, 2'b00, 16'h0, "both_sc");
    check("both_sc_lit", 32'(value_out[7:0]), 'h83);

    // Analog override on ch1
    tick(2'b10, 2'b00, 2'b00, 2'b10, 16'h0500, "ana_lo");
    check("ana_lo_lit", 32'(value_out[15:8]), 'h10);
    @(negedge clock_40);
    ana_in    = 16'hC300;
    btn_minus = 2'b10;
    repeat (8) @(negedge clock_40);
    check("ana_no_tick", 32'(value_out[15:8]), 'h10);
    tick(2'b00, 2'b10, 2'b00, 2'b10, 16'hC300, "ana_c3");
    check("ana_c3_lit", 32'(value_out[15:8]), 'hC3);

    // vsync held high: exactly one update, 4 clocks after the rise
    @(negedge clock_40);
    btn_plus = 2'b11; btn_minus = 2'b00; self_center = 2'b00; ana_en = 2'b00;
    vsync = 1'b1;
    repeat (3) @(negedge clock_40);
    check_all("vs_pre");
    @(negedge clock_40);
    model_tick();
    check_all("vs_upd");
    repeat (1000) @(negedge clock_40);
    check_all("vs_stay");
    vsync = 1'b0;
    repeat (6) @(negedge clock_40);
    check_all("vs_fall");

    // Randomized frames
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [1:0] ae;
      ae[0] = ($urandom_range(0, 7) == 0);
      ae[1] = ($urandom_range(0, 7) == 0);
      tick(2'($urandom), 2'($urandom), 2'($urandom), ae, 16'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
